multi_frame_writer: RTL and testbench
=====================================

MULTI_FRAME_WRITER -- requirements
Module: multi_frame_writer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 32, pixel / AXI data width (bits).
  ADDR_WIDTH, 32, byte address width.
  BURST_LEN, 16, maximum beats per write burst (power of 2, 2..256).
  NUM_BUFFERS, 3, frame buffers in the ring (1..8).
  BASE_ADDR, 0, byte address of buffer 0.
  FRAME_STRIDE, 32'h0010_0000, byte distance between consecutive buffers.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on rising edge.
  rst_n  in  1  asynchronous, active-low reset.
  s_axis_tdata  in  DATA_WIDTH  pixel.
  s_axis_tvalid  in  1  pixel valid.
  s_axis_tready  out  1  pixel accepted when tvalid&tready.
  s_axis_tlast  in  1  end of line.
  s_axis_tuser  in  1  start of frame (first pixel).
  pixels_per_frame  in  32  pixels per frame.
  frame_width  in  16  pixels per line.
  frame_height  in  16  lines per frame (informational only).
  start_write  out  1  one-cycle burst command strobe.
  write_addr  out  ADDR_WIDTH  burst start byte address.
  write_len  out  32  beats-1.
  write_size  out  3  log2(DATA_WIDTH/8).
  write_burst  out  2  constant 2'b01 (INCR).
  write_data  out  DATA_WIDTH  burst beat data.
  write_strb  out  DATA_WIDTH/8  all ones.
  write_valid  out  1  beat valid.
  write_ready  in  1  beat accepted when write_valid&write_ready.
  write_done  in  1  one-cycle pulse: burst response received.
  frame_ready  out  1  one-cycle pulse: frame fully written.
  base_addr_out  out  ADDR_WIDTH  base of the completed buffer.
  buf_index  out  3  buffer currently being written.
  frame_error  out  1  one-cycle pulse: protocol error.

Function
REQ-003 FSM states SHALL be IDLE, FILL, CMD, DATA, RESP; the FSM SHALL start in IDLE.
REQ-004 IDLE: s_axis_tready=1; beats without tuser SHALL be consumed and dropped; a beat with tuser SHALL latch pixels_per_frame/frame_width, reset the pixel counter and offset to 0, store the pixel, and enter FILL.
REQ-005 FILL: s_axis_tready SHALL equal FIFO-not-full; accepted pixels SHALL be pushed into the FIFO.
REQ-006 FILL→CMD SHALL occur in the cycle after the FIFO holds BURST_LEN beats or the frame's last pixel (count = pixels_per_frame) is accepted.
REQ-007 CMD SHALL last exactly one cycle with start_write=1, write_addr=BASE_ADDR+buf_index*FRAME_STRIDE+offset, write_len=beats-1; then DATA.
REQ-008 DATA: write_valid SHALL be 1 while the FIFO is non-empty, write_data=FIFO head, pop on write_valid&write_ready; last pop → RESP; s_axis_tready=0.
REQ-009 RESP: s_axis_tready=0; on write_done offset SHALL advance by beats*DATA_WIDTH/8; then FILL if the frame is incomplete, else frame completion.
REQ-010 Frame completion SHALL, in the write_done cycle+1, pulse frame_ready, set base_addr_out to the completed buffer's base, advance buf_index modulo NUM_BUFFERS (NUM_BUFFERS-1 wraps to 0), and enter IDLE.
REQ-011 tuser on an accepted beat in FILL with pixel count ≠ 0 SHALL pulse frame_error, flush the FIFO, reset count and offset, keep buf_index, and store that beat as pixel 0.
REQ-012 tlast on a pixel whose (count mod frame_width) ≠ frame_width-1 SHALL pulse frame_error without aborting the frame.
REQ-013 Final burst of a frame SHALL be partial when pixels_per_frame mod BURST_LEN ≠ 0.
REQ-014 Pixel counter SHALL be 32 bits; offset and address arithmetic SHALL be ADDR_WIDTH bits, wrapping modulo 2^ADDR_WIDTH.
REQ-015 write_done outside RESP SHALL be ignored.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, buf_index=0, FIFO empty, counters 0, base_addr_out=BASE_ADDR, and all strobes, write_valid, s_axis_tready and frame_error to 0; write_size and write_burst SHALL remain constant.
REQ-017 Reset mid-burst SHALL abandon the burst; no frame_ready SHALL follow.

Structure
REQ-018 Package mfw_pkg SHALL hold the FSM state enum, AXI_BURST_INCR=2'b01, and the size-encoding function.
REQ-019 The FIFO SHALL be a sub-module, pixel_burst_fifo (depth BURST_LEN, width DATA_WIDTH, push/pop/count).

Verification
REQ-020 4x2 frame, BURST_LEN=4, tuser on pixel 0 → two bursts: addr 0x00 and 0x10, write_len=3; one frame_ready with base_addr_out=0.
REQ-021 Four 8-pixel frames, NUM_BUFFERS=3, FRAME_STRIDE=0x100 → base_addr_out sequence 0x000, 0x100, 0x200, 0x000.
REQ-022 pixels_per_frame=6, BURST_LEN=4 → write_len 3 then 1, second addr 0x10.
REQ-023 write_ready toggling 1/0 each cycle → write_data sequence unchanged; s_axis_tready=0 throughout DATA/RESP.
REQ-024 tuser on pixel 3 of an 8-pixel frame → frame_error pulse, and that pixel is written at offset 0 of the same buffer.
REQ-025 rst_n low during DATA → all outputs at reset values next cycle; no frame_ready; next tuser frame starts at buffer 0.

Source files
------------

// File: rtl/mfw_pkg.sv
// Shared types for the multi-frame writer: FSM states, AXI burst encoding
// and the beat-size helper.
package mfw_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CMD,
      DATA,
      RESP
   } mfw_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   function automatic logic [2:0] axi_size(input int unsigned bytes);
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 8; i++)
         if (bytes == (32'd1 << i)) s = 3'(i);
      return s;
   endfunction

endpackage

// File: rtl/pixel_burst_fifo.sv
// Burst staging FIFO; clr empties it and may keep a beat pushed
// in the same cycle as the new head.
module pixel_burst_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    wr_sel;

   assign wr_sel = clr ? '0 : wr_ptr;
   assign dout   = mem[rd_ptr];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_sel] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= push ? AW'(1) : '0;
         count  <= push ? CW'(1) : '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/multi_frame_writer.sv
// Streams video frames into a ring of frame buffers as AXI-style
// INCR write bursts staged through a small pixel FIFO.
module multi_frame_writer
   import mfw_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BURST_LEN   = 16,
   parameter int unsigned NUM_BUFFERS = 3,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(32'h0010_0000)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   input  logic                    s_axis_tuser,
   input  logic [31:0]             pixels_per_frame,
   input  logic [15:0]             frame_width,
   input  logic [15:0]             frame_height,
   output logic                    start_write,
   output logic [ADDR_WIDTH-1:0]   write_addr,
   output logic [31:0]             write_len,
   output logic [2:0]              write_size,
   output logic [1:0]              write_burst,
   output logic [DATA_WIDTH-1:0]   write_data,
   output logic [DATA_WIDTH/8-1:0] write_strb,
   output logic                    write_valid,
   input  logic                    write_ready,
   input  logic                    write_done,
   output logic                    frame_ready,
   output logic [ADDR_WIDTH-1:0]   base_addr_out,
   output logic [2:0]              buf_index,
   output logic                    frame_error
);

   localparam int unsigned CW    = $clog2(BURST_LEN) + 1;
   localparam int unsigned BYTES = DATA_WIDTH / 8;

   mfw_state_t state, state_n;

   logic                  active;
   logic [31:0]           cnt, cnt_nx, ppf, ppf_nx;
   logic [15:0]           fw, fw_nx, col, col_cur;
   logic [ADDR_WIDTH-1:0] offset, buf_base;
   logic [CW-1:0]         fifo_count, beats;
   logic                  fifo_full, fifo_empty;
   logic                  acc, push, pop, clr, restart, err_nx;
   logic                  frame_last;
   logic                  unused_height;

   assign unused_height = ^frame_height;

   assign buf_base    = BASE_ADDR + ADDR_WIDTH'(buf_index) * FRAME_STRIDE;
   assign write_addr  = buf_base + offset;
   assign write_len   = 32'(fifo_count) - 32'd1;
   assign write_size  = axi_size(BYTES);
   assign write_burst = AXI_BURST_INCR;
   assign write_strb  = '1;
   assign frame_last  = (cnt == ppf);

   pixel_burst_fifo #(
      .DEPTH (BURST_LEN),
      .WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (s_axis_tdata),
      .dout  (write_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n       = state;
      s_axis_tready = 1'b0;
      start_write   = 1'b0;
      write_valid   = 1'b0;
      acc           = 1'b0;
      pop           = 1'b0;
      clr           = 1'b0;
      restart       = 1'b0;
      err_nx        = 1'b0;
      cnt_nx        = cnt + 32'd1;
      ppf_nx        = ppf;
      fw_nx         = fw;
      col_cur       = col;
      unique case (state)
         IDLE: begin
            s_axis_tready = active;
            acc           = s_axis_tvalid && active;
            restart       = acc && s_axis_tuser;
         end
         FILL: begin
            s_axis_tready = !fifo_full;
            acc           = s_axis_tvalid && !fifo_full;
            restart       = acc && s_axis_tuser && (cnt != '0);
            clr           = restart;
            err_nx        = restart;
         end
         CMD: begin
            start_write = 1'b1;
            state_n     = DATA;
         end
         DATA: begin
            write_valid = !fifo_empty;
            pop         = write_valid && write_ready;
            if (pop && fifo_count == CW'(1)) state_n = RESP;
         end
         RESP: begin
            if (write_done) state_n = frame_last ? IDLE : FILL;
         end
         default: state_n = IDLE;
      endcase
      push = restart || (acc && state == FILL);
      if (restart) begin
         cnt_nx  = 32'd1;
         ppf_nx  = pixels_per_frame;
         fw_nx   = frame_width;
         col_cur = '0;
      end
      // a burst closes as soon as the FIFO fills or the frame ends
      if (push) begin
         err_nx = err_nx || (s_axis_tlast && col_cur != fw_nx - 16'd1);
         if (cnt_nx == ppf_nx ||
             (!clr && fifo_count == CW'(BURST_LEN - 1)))
            state_n = CMD;
         else
            state_n = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active        <= 1'b0;
         cnt           <= '0;
         ppf           <= '0;
         fw            <= '0;
         col           <= '0;
         offset        <= '0;
         beats         <= '0;
         buf_index     <= '0;
         base_addr_out <= BASE_ADDR;
         frame_ready   <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         active      <= 1'b1;
         frame_ready <= 1'b0;
         frame_error <= err_nx;
         if (restart) begin
            ppf    <= ppf_nx;
            fw     <= fw_nx;
            offset <= '0;
         end
         if (push) begin
            cnt <= cnt_nx;
            col <= (col_cur == fw_nx - 16'd1) ? '0 : col_cur + 16'd1;
         end
         if (start_write) beats <= fifo_count;
         if (state == RESP && write_done) begin
            offset <= offset + ADDR_WIDTH'(beats) * ADDR_WIDTH'(BYTES);
            if (frame_last) begin
               frame_ready   <= 1'b1;
               base_addr_out <= buf_base;
               buf_index     <= (buf_index == 3'(NUM_BUFFERS - 1)) ?
                                '0 : buf_index + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_frame_writer.sv
// Directed scoreboard bench for multi_frame_writer (BURST_LEN=4,
// three buffers, stride 0x100).
module tb_multi_frame_writer;

   localparam int          BL     = 4;
   localparam int          NB     = 3;
   localparam logic [31:0] STRIDE = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic [31:0] pixels_per_frame = 32'd8;
   logic [15:0] frame_width = 16'd4;
   logic [15:0] frame_height = 16'd2;
   logic        start_write;
   logic [31:0] write_addr;
   logic [31:0] write_len;
   logic [2:0]  write_size;
   logic [1:0]  write_burst;
   logic [31:0] write_data;
   logic [3:0]  write_strb;
   logic        write_valid;
   logic        write_ready = 1'b1;
   logic        write_done = 1'b0;
   logic        frame_ready;
   logic [31:0] base_addr_out;
   logic [2:0]  buf_index;
   logic        frame_error;

   always #5 clk = ~clk;

   multi_frame_writer #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .BURST_LEN    (BL),
      .NUM_BUFFERS  (NB),
      .BASE_ADDR    (32'h0),
      .FRAME_STRIDE (STRIDE)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tready    (s_axis_tready),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tuser     (s_axis_tuser),
      .pixels_per_frame (pixels_per_frame),
      .frame_width      (frame_width),
      .frame_height     (frame_height),
      .start_write      (start_write),
      .write_addr       (write_addr),
      .write_len        (write_len),
      .write_size       (write_size),
      .write_burst      (write_burst),
      .write_data       (write_data),
      .write_strb       (write_strb),
      .write_valid      (write_valid),
      .write_ready      (write_ready),
      .write_done       (write_done),
      .frame_ready      (frame_ready),
      .base_addr_out    (base_addr_out),
      .buf_index        (buf_index),
      .frame_error      (frame_error)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] q_addr[$];
   logic [31:0] q_len[$];
   logic [31:0] q_data[$];
   logic [31:0] q_base[$];

   int bufm = 0;
   int errs = 0;
   int due = 0;
   int beats_left = 0;
   bit toggle = 1'b0;
   bit last_done = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic px(input logic [31:0] d, input bit u, input bit l);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("px_tready_timeout", s_axis_tready, 1'b1);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int n, input int w,
                             input logic [31:0] seed, input int bad);
      int off, rem, b;
      logic [31:0] base;
      base = 32'(bufm) * STRIDE;
      off = 0;
      rem = n;
      while (rem > 0) begin
         b = (rem > BL) ? BL : rem;
         q_addr.push_back(base + 32'(off));
         q_len.push_back(32'(b - 1));
         off += b * 4;
         rem -= b;
      end
      for (int i = 0; i < n; i++) q_data.push_back(seed + 32'(i));
      q_base.push_back(base);
      bufm = (bufm + 1) % NB;
      pixels_per_frame = 32'(n);
      frame_width = 16'(w);
      for (int i = 0; i < n; i++)
         px(seed + 32'(i), i == 0, ((i % w) == w - 1) || (i == bad));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q_addr.size() + q_data.size() + q_base.size()) != 0 &&
             n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, q_addr.size() + q_data.size() + q_base.size(), 0);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (start_write) begin
               if (q_addr.size() == 0) chk("cmd_extra", start_write, 1'b0);
               else begin
                  chk("cmd_addr", write_addr, q_addr.pop_front());
                  chk("cmd_len", write_len, q_len.pop_front());
                  beats_left = int'(write_len) + 1;
               end
            end
            if (write_valid || due > 0 || write_done)
               chk("tready_busy", s_axis_tready, 1'b0);
            if (write_valid && write_ready) begin
               if (q_data.size() == 0) chk("data_extra", write_valid, 1'b0);
               else chk("wdata", write_data, q_data.pop_front());
               beats_left--;
               if (beats_left == 0) due = 2;
            end
            if (frame_ready) begin
               chk("fr_after_done", last_done, 1'b1);
               if (q_base.size() == 0) chk("frame_extra", frame_ready, 1'b0);
               else chk("base_addr_out", base_addr_out, q_base.pop_front());
            end
            if (frame_error) errs++;
            last_done = write_done;
            @(posedge clk);
            #1;
            write_done = 1'b0;
            if (due > 0) begin
               due--;
               if (due == 0) write_done = 1'b1;
            end
            write_ready = toggle ? ~write_ready : 1'b1;
         end
         begin
            repeat (20000) @(posedge clk);
            vectors++;
            miscompares++;
            $error("FAIL watchdog: observed timeout expected completion");
         end
         begin
            #2;
            chk("rst_tready", s_axis_tready, 1'b0);
            chk("rst_start", start_write, 1'b0);
            chk("rst_wvalid", write_valid, 1'b0);
            chk("rst_fready", frame_ready, 1'b0);
            chk("rst_ferr", frame_error, 1'b0);
            chk("rst_buf", buf_index, 3'd0);
            chk("rst_base", base_addr_out, 32'h0);
            chk("rst_size", write_size, 3'd2);
            chk("rst_burst", write_burst, 2'b01);
            chk("rst_strb", write_strb, 4'hF);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);

            send_frame(8, 4, 32'hA100_0000, -1);
            drain("s1_drain");
            send_frame(6, 3, 32'hA200_0000, -1);
            drain("s2_drain");
            toggle = 1'b1;
            send_frame(8, 4, 32'hA300_0000, -1);
            drain("s3_drain");
            toggle = 1'b0;
            for (int f = 0; f < 4; f++)
               send_frame(8, 4, 32'hA400_0000 + 32'(f << 8), -1);
            drain("s4_drain");

            pixels_per_frame = 32'd8;
            frame_width = 16'd4;
            for (int i = 0; i < 3; i++) px(32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
            send_frame(8, 4, 32'hA500_0000, -1);
            drain("s5_drain");
            chk("err_none", errs, 0);

            px(32'hB000_0000, 1'b1, 1'b0);
            px(32'hB000_0001, 1'b0, 1'b0);
            px(32'hB000_0002, 1'b0, 1'b0);
            send_frame(8, 4, 32'hA600_0000, -1);
            drain("s6_drain");
            chk("err_restart", errs, 1);

            send_frame(8, 4, 32'hA700_0000, 1);
            drain("s7_drain");
            chk("err_tlast", errs, 2);

            pixels_per_frame = 32'd8;
            frame_width = 16'd4;
            q_addr.push_back(32'(bufm) * STRIDE);
            q_len.push_back(32'd3);
            for (int i = 0; i < 4; i++) q_data.push_back(32'hA800_0000 + 32'(i));
            for (int i = 0; i < 4; i++) px(32'hA800_0000 + 32'(i), i == 0, i == 3);
            for (int n = 0; n < 100 && !write_valid; n++) @(negedge clk);
            chk("s8_in_data", write_valid, 1'b1);
            #3;
            rst_n = 1'b0;
            #1;
            chk("mid_start", start_write, 1'b0);
            chk("mid_wvalid", write_valid, 1'b0);
            chk("mid_tready", s_axis_tready, 1'b0);
            chk("mid_fready", frame_ready, 1'b0);
            chk("mid_buf", buf_index, 3'd0);
            chk("mid_base", base_addr_out, 32'h0);
            chk("mid_size", write_size, 3'd2);
            chk("mid_burst", write_burst, 2'b01);
            q_addr.delete();
            q_len.delete();
            q_data.delete();
            q_base.delete();
            due = 0;
            beats_left = 0;
            bufm = 0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
            send_frame(8, 4, 32'hA900_0000, -1);
            drain("s8_drain");
            chk("err_final", errs, 2);
         end
      join_any
      disable fork;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
